pwm_fade_scheduler: RTL and testbench
=====================================

// Module: pwm_fade_scheduler
// PURPOSE
//  Sequences level updates into the 4-channel PWM driver's level registers. Holds a target level and a
//  fade rate per channel, and steps each channel's level one LSB toward its target at PWM-period boundaries.
//  Per-channel updates share a single level-write port, granted round-robin.
//  Sits between the configuration source (SPI front end or host) and the PWM level-register write port.
// PARAMETERS
//  NUM_CH   4  number of PWM channels scheduled (channel index width = clog2(NUM_CH))
//  LEVEL_W  8  PWM level width; level 0 = always off, 255 = always on
//  RATE_W   8  fade-rate field width
// PORTS
//  clk         in   1        single system clock; all state on posedge
//  reset_n     in   1        asynchronous, active-low reset
//  cfg_valid   in   1        config request
//  cfg_ready   out  1        config accepted when cfg_valid && cfg_ready
//  cfg_ch      in   2        channel to configure
//  cfg_target  in   LEVEL_W  target level
//  cfg_rate    in   RATE_W   0 = jump to target; R>0 = one LSB step every R period_end pulses
//  period_end  in   1        1-cycle pulse when the PWM counter wraps (254 -> 0)
//  wr_valid    out  1        level write to the PWM driver
//  wr_ready    in   1        write accepted when wr_valid && wr_ready
//  wr_addr     out  2        channel being written
//  wr_data     out  LEVEL_W  new level
//  fade_done   out  NUM_CH   1-cycle pulse when a channel's written level reaches its target
//  overrun     out  1        1-cycle pulse when period_end arrives while the scheduler is not IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - Outputs: cfg_ready=0, wr_valid=0, wr_addr=0, wr_data=0, fade_done=0, overrun=0.
//   - State: cur/target/rate/tick all 0, pending=0, FSM=IDLE, rr_last=NUM_CH-1.
//   - Reset mid-write drops wr_valid combinationally-fast; the in-flight write is abandoned.
//  Per-channel state: cur (last level written), target, rate, tick (RATE_W-bit counter), pending bit.
//  FSM states: IDLE, EVAL, ARB, WRITE.
//   - cfg_ready = (state==IDLE) and not in reset.
//   - Accepted cfg: target[ch]<=cfg_target, rate[ch]<=cfg_rate, tick[ch]<=0. cur is unchanged.
//   - IDLE:
//     - period_end -> EVAL.
//     - period_end in the same cycle as an accepted cfg: the cfg is applied first, then evaluated in EVAL.
//   - EVAL (1 cycle), per channel with cur!=target:
//     - rate==0: pending<=1.
//     - else: if tick+1==rate then tick<=0, pending<=1; else tick<=tick+1.
//     - Channels with cur==target: tick held at 0, no pending.
//     - Next state: ARB.
//   - ARB (1 cycle): pick the first pending channel searching rr_last+1 .. rr_last+NUM_CH (mod NUM_CH).
//     - None pending -> IDLE.
//     - Else rr_last<=ch; cur[ch]<=next; wr_addr<=ch; wr_data<=next; wr_valid<=1; -> WRITE.
//     - next = target if rate==0; cur+1 if cur<target; cur-1 if cur>target. No wrap: 255 never increments.
//   - WRITE: wr_valid, wr_addr, wr_data held stable until wr_ready.
//     - On handshake: wr_valid<=0, pending[ch]<=0; if wr_data==target[ch], fade_done[ch] pulses next cycle.
//     - Next state: ARB.
//  Latency: period_end in cycle k -> wr_valid first high in cycle k+3.
//   - wr_ready=1 throughput: one write per 2 cycles.
//  Overrun: period_end seen in EVAL/ARB/WRITE is dropped (ticks not advanced); overrun pulses next cycle.
//  A cfg to a channel whose cur already equals the new target produces no write and no fade_done.
// TESTING
//  1. Reset: reset_n=0 while wr_valid=1 -> wr_valid/cfg_ready drop at once.
//     After release: cfg_ready=1 next cycle; period_end yields no write.
//  2. Jump: cfg ch1 tgt=3 rate=0, period_end at k -> k+3: wr_valid, addr=1, data=3.
//     On ack: fade_done[1] pulses. A further period_end yields no write.
//  3. Slow fade: cfg ch0 tgt=2 rate=2, 4 period_ends -> writes only after pulses 2 and 4 (data 1, 2).
//     fade_done[0] pulses after the second write.
//  4. Round robin: all 4 ch rate=0, distinct targets, wr_ready low 2 cycles per write.
//     -> order 0,1,2,3; addr/data stable while stalled; cfg_ready=0 throughout.
//  5. Overrun: period_end while in WRITE with wr_ready=0 -> overrun pulse.
//     Tick counters unchanged; no extra writes afterwards.
//  6. Down fade: ch2 at 3, cfg tgt=1 rate=1 -> successive period_ends write 2 then 1; fade_done[2] on the 2nd.

Source files
------------

// File: rtl/pwm_fade_scheduler_if.sv
// Interface bundling the configuration, timing and level-write signals of the
// PWM fade scheduler.
//   slave  : scheduler side (takes cfg_* / period_end / wr_ready, drives the rest)
//   master : environment side (configuration source and PWM level-register port)
// Signals:
//   cfg_valid/cfg_ready/cfg_ch/cfg_target/cfg_rate : channel configuration handshake
//   period_end                                      : PWM period wrap pulse
//   wr_valid/wr_ready/wr_addr/wr_data               : level-register write handshake
//   fade_done                                       : per-channel fade-complete pulse
//   overrun                                         : period_end lost while busy
interface pwm_fade_scheduler_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LEVEL_W = 8,
  parameter int unsigned RATE_W  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [LEVEL_W-1:0] cfg_target;
  logic [RATE_W-1:0]  cfg_rate;
  logic               period_end;
  logic               wr_valid;
  logic               wr_ready;
  logic [CH_W-1:0]    wr_addr;
  logic [LEVEL_W-1:0] wr_data;
  logic [NUM_CH-1:0]  fade_done;
  logic               overrun;

  modport slave (
    input  cfg_valid,
    output cfg_ready,
    input  cfg_ch,
    input  cfg_target,
    input  cfg_rate,
    input  period_end,
    output wr_valid,
    input  wr_ready,
    output wr_addr,
    output wr_data,
    output fade_done,
    output overrun
  );

  modport master (
    output cfg_valid,
    input  cfg_ready,
    output cfg_ch,
    output cfg_target,
    output cfg_rate,
    output period_end,
    input  wr_valid,
    output wr_ready,
    input  wr_addr,
    input  wr_data,
    input  fade_done,
    input  overrun
  );
endinterface

// File: rtl/pwm_fade_scheduler.sv
// PWM fade scheduler: holds a target level and fade rate per channel and, at each
// PWM period boundary, steps every channel's level one LSB toward its target (or
// jumps straight there when rate is 0). Updates share one level-write port that is
// granted round-robin.
// Ports:
//   clk     : system clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus     : pwm_fade_scheduler_if.slave (config, period_end, level write, status)
module pwm_fade_scheduler #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LEVEL_W = 8,
  parameter int unsigned RATE_W  = 8
) (
  input logic                clk,
  input logic                reset_n,
  pwm_fade_scheduler_if.slave bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StEval, StArb, StWrite} state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] cur_q     [NUM_CH];
  logic [LEVEL_W-1:0] cur_d     [NUM_CH];
  logic [LEVEL_W-1:0] target_q  [NUM_CH];
  logic [LEVEL_W-1:0] target_d  [NUM_CH];
  logic [RATE_W-1:0]  rate_q    [NUM_CH];
  logic [RATE_W-1:0]  rate_d    [NUM_CH];
  logic [RATE_W-1:0]  tick_q    [NUM_CH];
  logic [RATE_W-1:0]  tick_d    [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [CH_W-1:0]    rr_last_q, rr_last_d;
  logic               wr_valid_q, wr_valid_d;
  logic [CH_W-1:0]    wr_addr_q, wr_addr_d;
  logic [LEVEL_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_CH-1:0]  fade_done_q, fade_done_d;
  logic               overrun_q, overrun_d;

  logic               cfg_ready;
  logic               cfg_fire;
  logic               arb_found;
  logic [CH_W-1:0]    arb_ch;
  logic [CH_W-1:0]    arb_cand;
  logic [LEVEL_W-1:0] arb_cur;
  logic [LEVEL_W-1:0] arb_tgt;
  logic [LEVEL_W-1:0] next_level;

  // Config is only taken while idle so tables never change under EVAL/ARB/WRITE.
  assign cfg_ready = (state_q == StIdle) && reset_n;
  assign cfg_fire  = bus.cfg_valid && cfg_ready;

  assign bus.cfg_ready = cfg_ready;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fade_done = fade_done_q;
  assign bus.overrun   = overrun_q;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    arb_cand  = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      arb_cand = CH_W'((32'(rr_last_q) + off) % NUM_CH);
      if (!arb_found && pending_q[arb_cand]) begin
        arb_found = 1'b1;
        arb_ch    = arb_cand;
      end
    end
  end

  // Level the granted channel moves to; cur<target guarantees no wrap at full scale.
  always_comb begin
    arb_cur = cur_q[arb_ch];
    arb_tgt = target_q[arb_ch];
    if (rate_q[arb_ch] == '0) begin
      next_level = arb_tgt;
    end else if (arb_cur < arb_tgt) begin
      next_level = arb_cur + LEVEL_W'(1);
    end else if (arb_cur > arb_tgt) begin
      next_level = arb_cur - LEVEL_W'(1);
    end else begin
      next_level = arb_cur;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    target_d    = target_q;
    rate_d      = rate_q;
    tick_d      = tick_q;
    pending_d   = pending_q;
    rr_last_d   = rr_last_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    fade_done_d = '0;
    // A period boundary while busy is dropped; only flag it.
    overrun_d   = bus.period_end && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          target_d[bus.cfg_ch] = bus.cfg_target;
          rate_d[bus.cfg_ch]   = bus.cfg_rate;
          tick_d[bus.cfg_ch]   = '0;
        end
        if (bus.period_end) begin
          state_d = StEval;
        end
      end

      StEval: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cur_q[i] != target_q[i]) begin
            if (rate_q[i] == '0) begin
              pending_d[i] = 1'b1;
            end else if (tick_q[i] + RATE_W'(1) == rate_q[i]) begin
              tick_d[i]    = '0;
              pending_d[i] = 1'b1;
            end else begin
              tick_d[i] = tick_q[i] + RATE_W'(1);
            end
          end else begin
            tick_d[i]    = '0;
            pending_d[i] = 1'b0;
          end
        end
        state_d = StArb;
      end

      StArb: begin
        if (arb_found) begin
          rr_last_d      = arb_ch;
          cur_d[arb_ch]  = next_level;
          wr_addr_d      = arb_ch;
          wr_data_d      = next_level;
          wr_valid_d     = 1'b1;
          state_d        = StWrite;
        end else begin
          state_d = StIdle;
        end
      end

      StWrite: begin
        if (bus.wr_ready) begin
          wr_valid_d           = 1'b0;
          pending_d[wr_addr_q] = 1'b0;
          if (wr_data_q == target_q[wr_addr_q]) begin
            fade_done_d[wr_addr_q] = 1'b1;
          end
          state_d = StArb;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i]    <= '0;
        target_q[i] <= '0;
        rate_q[i]   <= '0;
        tick_q[i]   <= '0;
      end
      pending_q   <= '0;
      rr_last_q   <= CH_W'(NUM_CH - 1);
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fade_done_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      rate_q      <= rate_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      rr_last_q   <= rr_last_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fade_done_q <= fade_done_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Directed bench for pwm_fade_scheduler: reset, jump, slow fade, round robin with
// stalls, overrun and down fade, each checked against hand-computed values.
module tb_pwm_fade_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] rr_tgt [4];

  pwm_fade_scheduler_if #(.NUM_CH(4), .LEVEL_W(8), .RATE_W(8)) bus ();

  pwm_fade_scheduler #(.NUM_CH(4), .LEVEL_W(8), .RATE_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, summary required before then", $time);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] rate);
    check("cfg_ready_before_cfg", bus.cfg_ready, 32'd1);
    bus.cfg_valid  = 1'b1;
    bus.cfg_ch     = ch;
    bus.cfg_target = tgt;
    bus.cfg_rate   = rate;
    tick();
    bus.cfg_valid  = 1'b0;
  endtask

  // One period_end with wr_ready held high: wr_valid must appear exactly at k+3.
  task automatic period_write(input string tag, input logic exp_wr, input logic [1:0] exp_addr,
                              input logic [7:0] exp_data, input logic [3:0] exp_done);
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    tick();
    check({tag, "_k2_no_valid"}, bus.wr_valid, 32'd0);
    tick();
    check({tag, "_k3_valid"}, bus.wr_valid, 32'(exp_wr));
    if (exp_wr) begin
      check({tag, "_addr"}, bus.wr_addr, 32'(exp_addr));
      check({tag, "_data"}, bus.wr_data, 32'(exp_data));
    end
    tick();
    check({tag, "_fade_done"}, bus.fade_done, 32'(exp_done));
    tick();
    check({tag, "_back_idle"}, bus.cfg_ready, 32'd1);
    check({tag, "_done_clear"}, bus.fade_done, 32'd0);
  endtask

  task automatic wait_wr_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (bus.wr_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_wr_valid"}, bus.wr_valid, 32'd1);
  endtask

  initial begin
    rr_tgt[0] = 8'd10;
    rr_tgt[1] = 8'd20;
    rr_tgt[2] = 8'd3;
    rr_tgt[3] = 8'd40;
    reset_n        = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_target = '0;
    bus.cfg_rate   = '0;
    bus.period_end = 1'b0;
    bus.wr_ready   = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_cfg_ready", bus.cfg_ready, 32'd0);
    check("rst_wr_valid", bus.wr_valid, 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_fade_done", bus.fade_done, 32'd0);
    check("rst_overrun", bus.overrun, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rel_cfg_ready", bus.cfg_ready, 32'd1);
    bus.wr_ready = 1'b1;
    period_write("rel_no_write", 1'b0, 2'd0, 8'd0, 4'b0000);

    // Reset while a write is stalled
    bus.wr_ready = 1'b0;
    do_cfg(2'd3, 8'd5, 8'd0);
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    tick();
    tick();
    check("midrst_valid", bus.wr_valid, 32'd1);
    check("midrst_addr", bus.wr_addr, 32'd3);
    check("midrst_data", bus.wr_data, 32'd5);
    reset_n = 1'b0;
    #1;
    check("midrst_valid_drop", bus.wr_valid, 32'd0);
    check("midrst_ready_drop", bus.cfg_ready, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_ready_back", bus.cfg_ready, 32'd1);
    check("midrst_no_valid", bus.wr_valid, 32'd0);

    // Jump
    bus.wr_ready = 1'b1;
    do_cfg(2'd1, 8'd3, 8'd0);
    period_write("jump", 1'b1, 2'd1, 8'd3, 4'b0010);
    period_write("jump_again", 1'b0, 2'd0, 8'd0, 4'b0000);
    do_cfg(2'd1, 8'd3, 8'd0);
    period_write("same_target", 1'b0, 2'd0, 8'd0, 4'b0000);

    // Slow fade: one step every second period
    do_cfg(2'd0, 8'd2, 8'd2);
    period_write("slow_p1", 1'b0, 2'd0, 8'd0, 4'b0000);
    period_write("slow_p2", 1'b1, 2'd0, 8'd1, 4'b0000);
    period_write("slow_p3", 1'b0, 2'd0, 8'd0, 4'b0000);
    period_write("slow_p4", 1'b1, 2'd0, 8'd2, 4'b0001);

    // Round robin from a fresh reset, two stall cycles per write
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_cfg(2'(i), rr_tgt[i], 8'd0);
    end
    bus.wr_ready = 1'b0;
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_wr_valid("rr", 4);
      check("rr_addr", bus.wr_addr, 32'(i));
      check("rr_data", bus.wr_data, 32'(rr_tgt[i]));
      check("rr_cfg_ready", bus.cfg_ready, 32'd0);
      tick();
      check("rr_stall_valid", bus.wr_valid, 32'd1);
      check("rr_stall_addr", bus.wr_addr, 32'(i));
      check("rr_stall_data", bus.wr_data, 32'(rr_tgt[i]));
      check("rr_stall_cfg_ready", bus.cfg_ready, 32'd0);
      bus.wr_ready = 1'b1;
      tick();
      bus.wr_ready = 1'b0;
      check("rr_ack_valid", bus.wr_valid, 32'd0);
      check("rr_fade_done", bus.fade_done, 32'd1 << i);
      check("rr_ack_cfg_ready", bus.cfg_ready, 32'd0);
    end
    tick();
    check("rr_end_idle", bus.cfg_ready, 32'd1);

    // Overrun during a stalled write; ch0 tick must not advance on the lost pulse
    do_cfg(2'd0, 8'd12, 8'd3);
    do_cfg(2'd3, 8'd41, 8'd0);
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    tick();
    tick();
    check("ovr_valid", bus.wr_valid, 32'd1);
    check("ovr_addr", bus.wr_addr, 32'd3);
    check("ovr_data", bus.wr_data, 32'd41);
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    check("ovr_pulse", bus.overrun, 32'd1);
    tick();
    check("ovr_pulse_end", bus.overrun, 32'd0);
    check("ovr_still_valid", bus.wr_valid, 32'd1);
    bus.wr_ready = 1'b1;
    tick();
    check("ovr_fade_done", bus.fade_done, 32'b1000);
    check("ovr_ack_valid", bus.wr_valid, 32'd0);
    tick();
    check("ovr_no_extra1", bus.wr_valid, 32'd0);
    tick();
    check("ovr_no_extra2", bus.wr_valid, 32'd0);
    check("ovr_idle", bus.cfg_ready, 32'd1);
    period_write("ovr_p2", 1'b0, 2'd0, 8'd0, 4'b0000);
    period_write("ovr_p3", 1'b1, 2'd0, 8'd11, 4'b0000);

    // Down fade on ch2 (currently 3)
    do_cfg(2'd2, 8'd1, 8'd1);
    period_write("down1", 1'b1, 2'd2, 8'd2, 4'b0000);
    period_write("down2", 1'b1, 2'd2, 8'd1, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
